// File: rtl/ysyx_25030081_pc_unit_if.sv
// ysyx_25030081_pc_unit_if
// Fetch handshake between the PC unit and the IFU.
//   pc        : current PC offered to the IFU
//   pc_valid  : PC is offered and is held stable until accepted
//   ifu_ready : IFU accepts pc in a cycle where pc_valid=1
// Modports:
//   master : PC unit side (drives pc/pc_valid, samples ifu_ready)
//   slave  : IFU side (samples pc/pc_valid, drives ifu_ready)
interface ysyx_25030081_pc_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] pc;
  logic                  pc_valid;
  logic                  ifu_ready;

  modport master (output pc, output pc_valid, input ifu_ready);
  modport slave  (input pc, input pc_valid, output ifu_ready);
endinterface

// File: rtl/ysyx_25030081_pc_unit.sv
// ysyx_25030081_pc_unit
// Program-counter unit for the multi-cycle core. Holds the architectural
// PC, offers it to the IFU through a valid/ready handshake, resolves the
// next PC when an instruction commits, flags misaligned control-flow
// targets and counts retired instructions.
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   ifu            : fetch handshake (pc, pc_valid out; ifu_ready in)
//   commit_valid   : retiring instruction this cycle, qualifies the inputs below
//   branch         : control-flow class (000 seq, 001 jal, 010 jalr, 011 rsvd,
//                    100 beq, 101 bne, 110 blt(u), 111 bge(u))
//   zero, less     : ALU compare flags
//   rdata1, imm    : jalr base and sign-extended immediate
//   trap, mret     : exception entry / return for the retiring instruction
//   trap_vec, mepc : redirect targets, always valid
//   misalign       : one-cycle pulse after a commit whose target was misaligned
//   misalign_addr  : offending target, holds its last value
//   retire_cnt     : committed instruction count, wraps silently
module ysyx_25030081_pc_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
  parameter bit                    COMPRESSED = 1'b0,
  parameter int                    CNT_WIDTH  = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  ysyx_25030081_pc_unit_if.master        ifu,
  input  logic                           commit_valid,
  input  logic [2:0]                     branch,
  input  logic                           zero,
  input  logic                           less,
  input  logic [DATA_WIDTH-1:0]          rdata1,
  input  logic [DATA_WIDTH-1:0]          imm,
  input  logic                           trap,
  input  logic                           mret,
  input  logic [DATA_WIDTH-1:0]          trap_vec,
  input  logic [DATA_WIDTH-1:0]          mepc,
  output logic                           misalign,
  output logic [DATA_WIDTH-1:0]          misalign_addr,
  output logic [CNT_WIDTH-1:0]           retire_cnt
);

  typedef enum logic {ISSUE, EXEC} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  mis_q, mis_d;
  logic [DATA_WIDTH-1:0] mis_addr_q, mis_addr_d;

  logic [DATA_WIDTH-1:0] seq_pc;
  logic [DATA_WIDTH-1:0] cf_target;
  logic                  cf_taken;
  logic                  cf_misaligned;

  // Control-flow target for the non-trap, non-mret case. jalr clears bit 0
  // of its sum, so it can only fail the 4-byte check (via bit 1).
  // Only a target that is actually taken is checked for alignment.
  always_comb begin
    seq_pc    = pc_q + DATA_WIDTH'(4);
    cf_target = pc_q + imm;
    cf_taken  = 1'b0;
    unique case (branch)
      3'b001:  cf_taken = 1'b1;
      3'b010: begin
        cf_target = (rdata1 + imm) & {{(DATA_WIDTH-1){1'b1}}, 1'b0};
        cf_taken  = 1'b1;
      end
      3'b100:  cf_taken = zero;
      3'b101:  cf_taken = ~zero;
      3'b110:  cf_taken = less;
      3'b111:  cf_taken = ~less;
      default: cf_taken = 1'b0;
    endcase
    if (COMPRESSED) begin
      cf_misaligned = cf_taken & cf_target[0];
    end else begin
      cf_misaligned = cf_taken & (|cf_target[1:0]);
    end
  end

  // Next-state logic. The PC is offered whenever the FSM sits in ISSUE, so
  // the offer reappears the cycle after a commit. commit_valid seen in ISSUE
  // is a protocol violation and is deliberately ignored. A misaligned target
  // redirects to trap_vec and does not count as a retirement.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    mis_d      = 1'b0;
    mis_addr_d = mis_addr_q;
    unique case (state_q)
      ISSUE: begin
        if (ifu.ifu_ready) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (commit_valid) begin
          state_d = ISSUE;
          if (trap) begin
            pc_d  = trap_vec;
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end else if (mret) begin
            pc_d  = mepc;
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end else if (cf_misaligned) begin
            pc_d       = trap_vec;
            mis_d      = 1'b1;
            mis_addr_d = cf_target;
          end else begin
            pc_d  = cf_taken ? cf_target : seq_pc;
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = ISSUE;
    endcase
  end

  // State registers; reset wins over any commit in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ISSUE;
      pc_q       <= RESET_PC;
      cnt_q      <= '0;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  assign ifu.pc        = pc_q;
  assign ifu.pc_valid  = (state_q == ISSUE);
  assign misalign      = mis_q;
  assign misalign_addr = mis_addr_q;
  assign retire_cnt    = cnt_q;

endmodule

// File: tb/tb_ysyx_25030081_pc_unit.sv
// tb_ysyx_25030081_pc_unit
// Drives two PC units with identical stimulus: dut_a uses 4-byte alignment
// and a 4-bit retire counter (so wrap is reachable), dut_b uses 2-byte
// alignment and the full 64-bit counter. A per-DUT behavioural model is
// advanced on every rising edge and compared with the DUT on every falling
// edge after reset; directed literal checks pin the model.
module tb_ysyx_25030081_pc_unit;

  localparam logic [31:0] RST_PC  = 32'h8000_0000;
  localparam logic [31:0] DEF_VEC = 32'h8000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_ready = 1'b0;
  logic        commit_valid = 1'b0;
  logic [2:0]  branch = 3'b000;
  logic        zero = 1'b0;
  logic        less = 1'b0;
  logic [31:0] rdata1 = '0;
  logic [31:0] imm = '0;
  logic        trap = 1'b0;
  logic        mret = 1'b0;
  logic [31:0] trap_vec = DEF_VEC;
  logic [31:0] mepc = 32'h8000_0200;

  logic        mis_a, mis_b;
  logic [31:0] maddr_a, maddr_b;
  logic [3:0]  cnt_a;
  logic [63:0] cnt_b;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ysyx_25030081_pc_unit_if #(.DATA_WIDTH(32)) if_a ();
  ysyx_25030081_pc_unit_if #(.DATA_WIDTH(32)) if_b ();
  assign if_a.ifu_ready = ifu_ready;
  assign if_b.ifu_ready = ifu_ready;

  ysyx_25030081_pc_unit #(.DATA_WIDTH(32), .RESET_PC(RST_PC), .COMPRESSED(1'b0), .CNT_WIDTH(4)) dut_a (
    .clk(clk), .rst(rst), .ifu(if_a.master), .commit_valid(commit_valid), .branch(branch),
    .zero(zero), .less(less), .rdata1(rdata1), .imm(imm), .trap(trap), .mret(mret),
    .trap_vec(trap_vec), .mepc(mepc), .misalign(mis_a), .misalign_addr(maddr_a), .retire_cnt(cnt_a)
  );

  ysyx_25030081_pc_unit #(.DATA_WIDTH(32), .RESET_PC(RST_PC), .COMPRESSED(1'b1), .CNT_WIDTH(64)) dut_b (
    .clk(clk), .rst(rst), .ifu(if_b.master), .commit_valid(commit_valid), .branch(branch),
    .zero(zero), .less(less), .rdata1(rdata1), .imm(imm), .trap(trap), .mret(mret),
    .trap_vec(trap_vec), .mepc(mepc), .misalign(mis_b), .misalign_addr(maddr_b), .retire_cnt(cnt_b)
  );

  // Behavioural model: index 0 mirrors dut_a, index 1 mirrors dut_b.
  logic [31:0] m_pc[2];
  logic        m_busy[2];
  logic [63:0] m_cnt[2];
  logic        m_mis[2];
  logic [31:0] m_maddr[2];
  logic        m_init = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One instruction's worth of architectural behaviour per call.
  task automatic modelStep(input int k);
    logic [31:0] tgt;
    logic        jump;
    logic        bad;
    m_mis[k] = 1'b0;
    if (rst) begin
      m_pc[k] = RST_PC; m_busy[k] = 1'b0; m_cnt[k] = '0; m_maddr[k] = '0;
    end else if (!m_busy[k]) begin
      if (ifu_ready) m_busy[k] = 1'b1;
    end else if (commit_valid) begin
      m_busy[k] = 1'b0;
      if (trap) begin
        m_pc[k] = trap_vec; m_cnt[k] = m_cnt[k] + 1;
      end else if (mret) begin
        m_pc[k] = mepc; m_cnt[k] = m_cnt[k] + 1;
      end else begin
        tgt = m_pc[k] + imm;
        jump = 1'b1;
        case (branch)
          3'd0, 3'd3: jump = 1'b0;
          3'd2: tgt = (rdata1 + imm) & 32'hFFFF_FFFE;
          3'd4: jump = zero;
          3'd5: jump = !zero;
          3'd6: jump = less;
          3'd7: jump = !less;
          default: jump = 1'b1;
        endcase
        bad = (k == 1) ? (tgt % 2 != 0) : (tgt % 4 != 0);
        if (!jump) begin
          m_pc[k] = m_pc[k] + 4; m_cnt[k] = m_cnt[k] + 1;
        end else if (bad) begin
          m_mis[k] = 1'b1; m_maddr[k] = tgt; m_pc[k] = trap_vec;
        end else begin
          m_pc[k] = tgt; m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    modelStep(0);
    modelStep(1);
    if (rst) m_init = 1'b1;
  end

  // Per-cycle scoreboard compare, away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      checkOutput("a_pc",       64'(if_a.pc),       64'(m_pc[0]));
      checkOutput("a_pc_valid", 64'(if_a.pc_valid), 64'(!m_busy[0]));
      checkOutput("a_misalign", 64'(mis_a),         64'(m_mis[0]));
      checkOutput("a_mis_addr", 64'(maddr_a),       64'(m_maddr[0]));
      checkOutput("a_retire",   64'(cnt_a),         m_cnt[0] & 64'hF);
      checkOutput("b_pc",       64'(if_b.pc),       64'(m_pc[1]));
      checkOutput("b_pc_valid", 64'(if_b.pc_valid), 64'(!m_busy[1]));
      checkOutput("b_misalign", 64'(mis_b),         64'(m_mis[1]));
      checkOutput("b_mis_addr", 64'(maddr_b),       64'(m_maddr[1]));
      checkOutput("b_retire",   cnt_b,              m_cnt[1]);
    end
  end

  // All driving tasks start and end just after a falling edge.
  task automatic doIssue();
    ifu_ready = 1'b1;
    @(negedge clk);
    ifu_ready = 1'b0;
  endtask

  task automatic doCommit(input logic [2:0] br, input logic z, input logic l,
                          input logic [31:0] r1, input logic [31:0] im,
                          input logic tr, input logic mr);
    branch = br; zero = z; less = l; rdata1 = r1; imm = im; trap = tr; mret = mr;
    commit_valid = 1'b1;
    @(negedge clk);
    commit_valid = 1'b0; branch = 3'b000; trap = 1'b0; mret = 1'b0;
  endtask

  task automatic applyStimulus(input logic [2:0] br, input logic z, input logic l,
                               input logic [31:0] r1, input logic [31:0] im,
                               input logic tr, input logic mr);
    doIssue();
    doCommit(br, z, l, r1, im, tr, mr);
  endtask

  // Jump anywhere via an (unchecked) trap redirect.
  task automatic setPc(input logic [31:0] v);
    trap_vec = v;
    applyStimulus(3'b000, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    trap_vec = DEF_VEC;
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b0;
    checkOutput("lit_reset_pc",    64'(if_a.pc),       64'h8000_0000);
    checkOutput("lit_reset_valid", 64'(if_a.pc_valid), 64'd1);
    checkOutput("lit_reset_cnt",   cnt_b,              64'd0);

    doIssue();
    checkOutput("lit_exec_valid", 64'(if_a.pc_valid), 64'd0);
    doCommit(3'b000, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("lit_seq_pc",    64'(if_a.pc),       64'h8000_0004);
    checkOutput("lit_seq_valid", 64'(if_a.pc_valid), 64'd1);
    checkOutput("lit_seq_cnt",   64'(cnt_a),         64'd1);

    setPc(32'h8000_0010);
    applyStimulus(3'b100, 1'b1, 1'b0, '0, 32'hFFFF_FFF0, 1'b0, 1'b0);
    checkOutput("lit_beq_taken", 64'(if_a.pc), 64'h8000_0000);
    setPc(32'h8000_0010);
    applyStimulus(3'b100, 1'b0, 1'b0, '0, 32'hFFFF_FFF0, 1'b0, 1'b0);
    checkOutput("lit_beq_not", 64'(if_a.pc), 64'h8000_0014);
    setPc(32'h8000_0010);
    applyStimulus(3'b111, 1'b0, 1'b0, '0, 32'd8, 1'b0, 1'b0);
    checkOutput("lit_bge_taken", 64'(if_a.pc), 64'h8000_0018);

    applyStimulus(3'b010, 1'b0, 1'b0, 32'h8000_1001, 32'd2, 1'b0, 1'b0);
    checkOutput("lit_jalr_b_pc",  64'(if_b.pc), 64'h8000_1002);
    checkOutput("lit_jalr_b_mis", 64'(mis_b),   64'd0);
    checkOutput("lit_jalr_a_mis", 64'(mis_a),   64'd1);
    checkOutput("lit_jalr_a_adr", 64'(maddr_a), 64'h8000_1002);
    checkOutput("lit_jalr_a_pc",  64'(if_a.pc), 64'h8000_0100);
    checkOutput("lit_jalr_a_cnt", 64'(cnt_a),   64'd7);
    checkOutput("lit_jalr_b_cnt", cnt_b,        64'd8);
    @(negedge clk);
    checkOutput("lit_mis_pulse", 64'(mis_a), 64'd0);

    setPc(32'h8000_0010);
    applyStimulus(3'b100, 1'b0, 1'b0, '0, 32'd2, 1'b0, 1'b0);
    checkOutput("lit_nt_no_flag", 64'(mis_a), 64'd0);
    applyStimulus(3'b001, 1'b0, 1'b0, '0, 32'd3, 1'b0, 1'b0);
    checkOutput("lit_jal_odd_b", 64'(mis_b), 64'd1);
    applyStimulus(3'b001, 1'b0, 1'b0, '0, 32'd2, 1'b0, 1'b0);
    checkOutput("lit_jal2_b_pc", 64'(if_b.pc), 64'h8000_0102);

    applyStimulus(3'b001, 1'b0, 1'b0, '0, 32'd8, 1'b1, 1'b1);
    checkOutput("lit_trap_wins", 64'(if_a.pc), 64'h8000_0100);
    applyStimulus(3'b000, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("lit_mret", 64'(if_a.pc), 64'h8000_0200);

    commit_valid = 1'b1;
    repeat (5) @(negedge clk);
    commit_valid = 1'b0;
    checkOutput("lit_hold_pc",    64'(if_a.pc),       64'h8000_0200);
    checkOutput("lit_hold_valid", 64'(if_a.pc_valid), 64'd1);
    checkOutput("lit_hold_cnt_a", 64'(cnt_a),         64'd11);
    checkOutput("lit_hold_cnt_b", cnt_b,              64'd13);

    doIssue();
    rst = 1'b1; commit_valid = 1'b1; branch = 3'b001; imm = 32'd8;
    @(negedge clk);
    rst = 1'b0; commit_valid = 1'b0; branch = 3'b000;
    checkOutput("lit_rst_pc",    64'(if_a.pc),       64'h8000_0000);
    checkOutput("lit_rst_valid", 64'(if_a.pc_valid), 64'd1);
    checkOutput("lit_rst_cnt",   cnt_b,              64'd0);

    setPc(32'hFFFF_FFFC);
    applyStimulus(3'b000, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("lit_pc_wrap", 64'(if_a.pc), 64'h0000_0000);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) applyStimulus(3'b011, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("lit_cnt_full", 64'(cnt_a), 64'd15);
    applyStimulus(3'b000, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("lit_cnt_wrap_a", 64'(cnt_a), 64'd0);
    checkOutput("lit_cnt_b",      cnt_b,      64'd16);

    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ysyx_25030081_pc_unit.md
Name: ysyx_25030081_pc_unit

Overview:
- Sequential program-counter unit for the multi-cycle core.
- Holds the architectural PC and offers it to the IFU with a valid/ready handshake.
- Resolves the next PC at instruction commit from branch, jump, trap and mret inputs, and flags misaligned control-flow targets.
- Counts retired instructions.

Parameters:
DATA_WIDTH, 32, width of PC, operands and targets
RESET_PC, 32'h8000_0000, PC value loaded on reset
COMPRESSED, 0, 1 = 2-byte alignment required, 0 = 4-byte alignment required
CNT_WIDTH, 64, width of the retire counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
pc  out  DATA_WIDTH  current PC offered to IFU
pc_valid  out  1  PC offered; held stable until accepted
ifu_ready  in  1  IFU accepts pc this cycle when pc_valid=1
commit_valid  in  1  current instruction retires this cycle; qualifies all inputs below
branch  in  3  control-flow class of the retiring instruction
zero  in  1  ALU equal flag
less  in  1  ALU less-than flag (signedness chosen upstream)
rdata1  in  DATA_WIDTH  rs1 value for jalr
imm  in  DATA_WIDTH  sign-extended immediate
trap  in  1  retiring instruction raises a trap (ecall/ebreak/illegal)
mret  in  1  retiring instruction is mret
trap_vec  in  DATA_WIDTH  mtvec value, always valid
mepc  in  DATA_WIDTH  mepc value, always valid
misalign  out  1  one-cycle pulse: computed target was misaligned
misalign_addr  out  DATA_WIDTH  offending target; valid while misalign=1, otherwise holds last value
retire_cnt  out  CNT_WIDTH  number of committed instructions

Behaviour:
Reset (rst=1 at an edge):
- pc=RESET_PC, pc_valid=1, state=ISSUE, misalign=0, misalign_addr=0, retire_cnt=0.
- rst overrides every other input in the same cycle, including mid-commit.

State ISSUE:
- pc_valid=1; pc is stable.
- On pc_valid & ifu_ready: go to EXEC, pc_valid=0 next cycle.
- commit_valid is ignored in ISSUE; it is a protocol violation with no state change.

State EXEC:
- pc_valid=0; wait for commit_valid.
- On commit_valid: pc is loaded with next_pc, retire_cnt increments by 1, and the unit returns to ISSUE.
- pc_valid=1 in the cycle after the commit, giving one cycle of commit-to-offer latency.

next_pc priority:
1. trap=1: next_pc = trap_vec. Branch fields and mret are ignored.
2. mret=1: next_pc = mepc.
3. Otherwise decode branch:
- 000: pc+4
- 001 (jal): pc+imm
- 010 (jalr): (rdata1+imm) with bit0 cleared
- 011: reserved, treated as pc+4
- 100 beq: taken if zero
- 101 bne: taken if !zero
- 110 blt/bltu: taken if less
- 111 bge/bgeu: taken if !less
- A taken branch goes to pc+imm; a not-taken branch goes to pc+4.

Arithmetic:
- All sums are modulo 2^DATA_WIDTH; wrap-around is silent (e.g. pc=FFFF_FFFC, +4 gives 0).

Misalignment:
- Applies only to a priority-3 target that is actually selected (jal, jalr, or a taken branch).
- Misaligned means target[1:0]!=0 when COMPRESSED=0, or target[0]!=0 when COMPRESSED=1. jalr can only fail the COMPRESSED=0 check on bit1.
- On misalignment: next_pc = trap_vec, misalign=1 for exactly one cycle (the cycle after commit), misalign_addr = the target. retire_cnt does not increment, because the instruction faulted.
- Not-taken branches never flag, even if pc+imm is misaligned.
- trap_vec and mepc are loaded unchecked.

retire_cnt:
- Wraps to 0 after all-ones.

Test Plan:
- Reset, then ifu_ready=1 → pc=8000_0000, pc_valid=1 at the first post-reset cycle; after the handshake pc_valid=0; commit branch=000 → pc=8000_0004, pc_valid=1 one cycle later, retire_cnt=1.
- pc=8000_0010, branch=100: zero=1, imm=FFFF_FFF0 → pc=8000_0000. Repeat with zero=0 → pc=8000_0014. branch=111 with less=0, imm=8 → pc=8000_0018.
- branch=010, rdata1=8000_1001, imm=2 → pc=8000_1002, no misalign when COMPRESSED=1. With COMPRESSED=0 → misalign=1 for one cycle, misalign_addr=8000_1002, pc=trap_vec, retire_cnt unchanged.
- Commit with trap=1 and mret=1, branch=001, trap_vec=8000_0100, mepc=8000_0200 → pc=8000_0100 (trap wins). Commit with mret=1 only → pc=8000_0200.
- Hold ifu_ready=0 for 5 cycles with commit_valid pulsed in ISSUE → pc and pc_valid stable, retire_cnt unchanged. Assert rst during EXEC together with commit_valid → pc=RESET_PC, retire_cnt=0, state=ISSUE.
- pc=FFFF_FFFC, branch=000 → pc=0000_0000. Preload retire_cnt to all-ones (CNT_WIDTH=4 build) and commit → retire_cnt=0.
